// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, IDLE/FETCH/ERROR control and a small
// prefetch queue that delivers one instruction per cycle to the consumer.
//
// state | meaning
// IDLE  | fetch disabled, queue may still drain, redirects update PC
// FETCH | fetching one word per cycle into the queue while there is room
// ERROR | sticky fault; no fetch, redirects ignored, queue drains, left only by rst
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WIDTH = 256,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Run,
    output logic [31:0] Addr,
    input  logic [31:0] Instruction,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic        Error
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = PW + 1;
    localparam logic [31:0] LAST_PC = 32'(MEM_WIDTH - 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     pc;
    logic            err;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     q_instr [DEPTH];
    logic [31:0]     q_pc    [DEPTH];

    logic redirect_act;
    logic redirect_bad;
    logic pc_ok;
    logic range_fault;
    logic deq;
    logic enq;

    always_comb begin
        redirect_act = Redirect && (state != ERROR);
        redirect_bad = redirect_act && (RedirectPC[1:0] != 2'b00);
        pc_ok        = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
        range_fault  = (state == FETCH) && !pc_ok;
        deq          = (count != '0) && InstrReady && !redirect_act;
        enq          = (state == FETCH) && Run && !redirect_act && pc_ok
                       && ((count < CW'(DEPTH)) || deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            err    <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (redirect_act) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PW'(1);
                if (deq) rd_ptr <= rd_ptr + PW'(1);
                if (enq && !deq)      count <= count + CW'(1);
                else if (!enq && deq) count <= count - CW'(1);
            end

            // A misaligned redirect leaves PC where it was; ERROR then freezes it.
            if (redirect_act && !redirect_bad) pc <= RedirectPC;
            else if (enq)                      pc <= pc + 32'd4;

            if (state != ERROR) begin
                if (redirect_bad || (!redirect_act && range_fault)) begin
                    state <= ERROR;
                    err   <= 1'b1;
                end else begin
                    state <= Run ? FETCH : IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq) begin
            q_instr[wr_ptr] <= Instruction;
            q_pc[wr_ptr]    <= pc;
        end
    end

    always_comb begin
        Addr       = pc;
        Error      = err;
        InstrValid = (count != '0);
        InstrOut   = InstrValid ? q_instr[rd_ptr] : 32'h0;
        InstrPC    = InstrValid ? q_pc[rd_ptr]    : 32'h0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, one hand-written error-drain
// sequence, then random stimulus against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_WIDTH = 256;
    localparam int          DEPTH     = 2;

    logic        clk = 1'b0;
    logic        rst, Run, InstrReady, Redirect;
    logic [31:0] RedirectPC, Addr, Instruction, InstrOut, InstrPC;
    logic        InstrValid, Error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign Instruction = memf(Addr);

    fetch_unit #(.RESET_PC(RESET_PC), .MEM_WIDTH(MEM_WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .Run(Run), .Addr(Addr), .Instruction(Instruction),
        .InstrValid(InstrValid), .InstrReady(InstrReady), .InstrOut(InstrOut),
        .InstrPC(InstrPC), .Redirect(Redirect), .RedirectPC(RedirectPC), .Error(Error)
    );

    typedef struct {
        logic        rst, run, ready, redir;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        e_err;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic run, input logic rdy,
                        input logic rd, input logic [31:0] rpc);
        rst = r; Run = run; InstrReady = rdy; Redirect = rd; RedirectPC = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] ipc,
                              input logic ca, input logic [31:0] addr, input logic e);
        chk({tag, ".valid"}, {31'd0, InstrValid}, {31'd0, v});
        chk({tag, ".ipc"}, InstrPC, v ? ipc : 32'h0);
        chk({tag, ".iout"}, InstrOut, v ? memf(ipc) : 32'h0);
        if (ca) chk({tag, ".addr"}, Addr, addr);
        chk({tag, ".err"}, {31'd0, Error}, {31'd0, e});
    endtask

    function automatic vec_t mk(input logic r, input logic run, input logic rdy,
                                input logic rd, input logic [31:0] rpc, input logic v,
                                input logic [31:0] ipc, input logic ca,
                                input logic [31:0] addr, input logic e);
        vec_t t;
        t.rst = r; t.run = run; t.ready = rdy; t.redir = rd; t.rpc = rpc;
        t.e_valid = v; t.e_ipc = ipc; t.chk_addr = ca; t.e_addr = addr; t.e_err = e;
        return t;
    endfunction

    // reference model state
    typedef struct { logic [31:0] pc; logic [31:0] ins; } entry_t;
    entry_t      mq[$];
    logic [31:0] m_pc;
    int          m_mode;   // 0 idle, 1 fetching, 2 faulted
    logic        m_err;

    task automatic model_cycle(input logic r, input logic run, input logic rdy,
                               input logic rd, input logic [31:0] rpc);
        bit can_deq, fault, do_enq;
        entry_t e;
        if (r) begin
            mq.delete(); m_pc = RESET_PC; m_mode = 0; m_err = 1'b0;
        end else if (m_mode != 2 && rd) begin
            mq.delete();
            if (rpc[1:0] != 2'b00) begin m_mode = 2; m_err = 1'b1; end
            else begin m_pc = rpc; m_mode = run ? 1 : 0; end
        end else begin
            can_deq = (mq.size() > 0) && rdy;
            fault   = (m_mode == 1) && ((m_pc > 32'(MEM_WIDTH - 4)) || (m_pc[1:0] != 2'b00));
            do_enq  = (m_mode == 1) && run && !fault && ((mq.size() < DEPTH) || can_deq);
            e.pc = m_pc; e.ins = memf(m_pc);
            if (can_deq) void'(mq.pop_front());
            if (do_enq) begin mq.push_back(e); m_pc = m_pc + 32'd4; end
            if (m_mode != 2) begin
                if (fault) begin m_mode = 2; m_err = 1'b1; end
                else m_mode = run ? 1 : 0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; Run = 1'b0; InstrReady = 1'b0; Redirect = 1'b0; RedirectPC = 32'h0;

        //          rst run rdy rd  rpc           v  ipc          ca addr         err
        tv.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, RESET_PC,    0));
        // back-to-back delivery
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h0,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h0,        1, 32'h4,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h4,        1, 32'h8,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h8,        1, 32'hC,       0));
        // backpressure fills the queue, then release
        tv.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h4,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h8,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h8,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h8,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h8,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h4,        1, 32'hC,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h8,        1, 32'h10,      0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'hC,        1, 32'h14,      0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h10,       1, 32'h18,      0));
        // redirect with a full queue
        tv.push_back(mk(0, 1, 1, 1, 32'h40,       0, 32'h0,        1, 32'h40,      0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h40,       1, 32'h44,      0));
        // misaligned redirect: sticky error, later redirects ignored
        tv.push_back(mk(0, 1, 1, 1, 32'h42,       0, 32'h0,        0, 32'h0,       1));
        tv.push_back(mk(0, 1, 1, 1, 32'h80,       0, 32'h0,        0, 32'h0,       1));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,       1));
        tv.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, RESET_PC,    0));
        // run off the end of memory
        tv.push_back(mk(0, 1, 1, 1, 32'hF8,       0, 32'h0,        1, 32'hF8,      0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'hF8,       1, 32'hFC,      0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'hFC,       1, 32'h100,     0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h100,     1));
        tv.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,        1, RESET_PC,    0));
        // reset discards a queued entry even with InstrReady high
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,        1, 32'h4,       0));
        tv.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,        1, RESET_PC,    0));
        tv.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, RESET_PC,    0));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].rst, tv[i].run, tv[i].ready, tv[i].redir, tv[i].rpc);
            expect_out($sformatf("vec%0d", i), tv[i].e_valid, tv[i].e_ipc,
                       tv[i].chk_addr, tv[i].e_addr, tv[i].e_err);
        end

        // queued entries stay drainable after an out-of-range fault
        step(0, 1, 0, 1, 32'hF8); expect_out("drain0", 0, 32'h0,  1, 32'hF8,  0);
        step(0, 1, 0, 0, 32'h0);  expect_out("drain1", 1, 32'hF8, 1, 32'hFC,  0);
        step(0, 1, 0, 0, 32'h0);  expect_out("drain2", 1, 32'hF8, 1, 32'h100, 0);
        step(0, 1, 0, 0, 32'h0);  expect_out("drain3", 1, 32'hF8, 1, 32'h100, 1);
        step(0, 1, 1, 1, 32'h40); expect_out("drain4", 1, 32'hFC, 1, 32'h100, 1);
        step(0, 1, 1, 0, 32'h0);  expect_out("drain5", 0, 32'h0,  1, 32'h100, 1);

        // random stimulus against the reference model
        step(1, 0, 0, 0, 32'h0);
        model_cycle(1, 0, 0, 0, 32'h0);
        for (int c = 0; c < 3000; c++) begin
            logic        r, run, rdy, rd;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 59) == 0);
            run = ($urandom_range(0, 9) < 8);
            rdy = ($urandom_range(0, 9) < 6);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = 32'($urandom_range(0, 70)) * 32'd4;
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(r, run, rdy, rd, rpc);
            model_cycle(r, run, rdy, rd, rpc);
            if (mq.size() > 0) expect_out($sformatf("rnd%0d", c), 1, mq[0].pc, 1, m_pc, m_err);
            else               expect_out($sformatf("rnd%0d", c), 0, 32'h0,    1, m_pc, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
